video_luma_stage: RTL

Downstream consumer of the DVI pattern generator (or the live video source) and first stage of the feature-detection datapath. Accepts 24-bit RGB pixels over a valid/ready handshake, converts each to 8-bit luma in a two-stage pipeline, and tags every pixel with raster coordinates and frame/line markers. Backpressure from the downstream detector propagates upstream without dropping or duplicating pixels.

---
 rtl/video_luma_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/video_luma_stage.sv
// video_luma_stage
//   Converts 24-bit RGB pixels to 8-bit luma in a two-stage pipeline. Each
//   pixel is tagged with its raster coordinates and frame/line markers.
//   Valid/ready handshake on both sides. A downstream stall holds the whole
//   pipeline and propagates upstream combinationally.
//
// Ports
//   clock        single clock domain
//   reset        synchronous, active-high
//   Video        RGB pixel, R=[23:16] G=[15:8] B=[7:0]
//   VideoValid   upstream pixel valid
//   VideoReady   pixel accepted this cycle when VideoValid is also high
//   Luma         luma of the output pixel
//   LumaValid    output pixel valid
//   LumaReady    downstream accepts the output pixel
//   PixelX/Y     raster coordinates of the output pixel
//   StartOfFrame output tag is (0,0)  (qualify with LumaValid)
//   EndOfLine    output tag is the last column (qualify with LumaValid)
//   FrameCount   frames fully accepted since reset, wraps at 16 bits
module video_luma_stage #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] Video,
  input  logic        VideoValid,
  output logic        VideoReady,
  output logic [7:0]  Luma,
  output logic        LumaValid,
  input  logic        LumaReady,
  output logic [9:0]  PixelX,
  output logic [9:0]  PixelY,
  output logic        StartOfFrame,
  output logic        EndOfLine,
  output logic [15:0] FrameCount
);

  localparam logic [9:0] LastX = 10'(WIDTH - 1);
  localparam logic [9:0] LastY = 10'(HEIGHT - 1);

  logic        en;
  logic        accept;

  logic [9:0]  inX;
  logic [9:0]  inY;
  logic [15:0] frameCnt;

  // Green product needs 16 bits: 150*255 does not fit in 15.
  logic        s1Valid;
  logic [14:0] pR;
  logic [15:0] pG;
  logic [14:0] pB;
  logic [9:0]  s1X;
  logic [9:0]  s1Y;

  logic        s2Valid;
  logic [7:0]  lumaReg;
  logic [9:0]  s2X;
  logic [9:0]  s2Y;

  logic [15:0] sum;

  // Whole pipeline moves together; the output register frees up either when
  // it is empty or when downstream takes it this cycle.
  assign en         = !s2Valid || LumaReady;
  assign VideoReady = en && !reset;
  assign accept     = VideoValid && VideoReady;

  // Coefficients sum to 256, so the sum never exceeds 255*256.
  assign sum = 16'(pR) + pG + 16'(pB);

  always_ff @(posedge clock) begin
    if (reset) begin
      inX      <= '0;
      inY      <= '0;
      frameCnt <= '0;
    end else if (accept) begin
      if (inX == LastX) begin
        inX <= '0;
        if (inY == LastY) begin
          inY      <= '0;
          frameCnt <= frameCnt + 16'd1;
        end else begin
          inY <= inY + 10'd1;
        end
      end else begin
        inX <= inX + 10'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1Valid <= 1'b0;
      pR      <= '0;
      pG      <= '0;
      pB      <= '0;
      s1X     <= '0;
      s1Y     <= '0;
      s2Valid <= 1'b0;
      lumaReg <= '0;
      s2X     <= '0;
      s2Y     <= '0;
    end else if (en) begin
      s1Valid <= accept;
      pR      <= 15'(Video[23:16]) * 15'd77;
      pG      <= 16'(Video[15:8])  * 16'd150;
      pB      <= 15'(Video[7:0])   * 15'd29;
      s1X     <= inX;
      s1Y     <= inY;
      s2Valid <= s1Valid;
      lumaReg <= sum[15:8];
      s2X     <= s1X;
      s2Y     <= s1Y;
    end
  end

  assign LumaValid    = s2Valid;
  assign Luma         = lumaReg;
  assign PixelX       = s2X;
  assign PixelY       = s2Y;
  assign StartOfFrame = (s2X == 10'd0) && (s2Y == 10'd0);
  assign EndOfLine    = (s2X == LastX);
  assign FrameCount   = frameCnt;

endmodule
